// File: rtl/eth_pkg.sv
// Shared Ethernet/IPv4/UDP receive constants, FSM state encoding and CRC helpers.
package eth_pkg;
  localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
  localparam logic [7:0]  SFD_BYTE       = 8'hD5;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
  localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;
  localparam logic [31:0] CRC_POLY       = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT       = 32'hFFFFFFFF;
  // Good-frame residue, expressed MSB-first (bit-reversed view of the shift register).
  localparam logic [31:0] CRC_RESIDUE    = 32'hC704DD7B;

  typedef enum logic [3:0] {
    ST_IDLE, ST_PREAMBLE, ST_DST_MAC, ST_SRC_MAC, ST_TYPE, ST_IP_HDR,
    ST_UDP_HDR, ST_PAYLOAD, ST_PAD, ST_VERDICT, ST_DROP
  } rx_state_e;

  // One byte of reflected CRC32, LSB of the byte first.
  function automatic logic [31:0] crc32_d8(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] r;
    r = crc ^ {24'd0, d};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int k = 0; k < 32; k++) r[k] = v[31-k];
    return r;
  endfunction

  // Byte idx (0 = most significant) of a 48-bit / 32-bit network-order field.
  function automatic logic [7:0] byte_of48(input logic [47:0] v, input logic [2:0] idx);
    return 8'(v >> (6'd40 - {idx, 3'b000}));
  endfunction

  function automatic logic [7:0] byte_of32(input logic [31:0] v, input logic [1:0] idx);
    return 8'(v >> (5'd24 - {idx, 3'b000}));
  endfunction
endpackage

// File: rtl/eth_crc32_d8.sv
// Byte-wide reflected CRC32 accumulator; i_init has priority over i_en.
module eth_crc32_d8 import eth_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_init,
  input  logic        i_en,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);
  logic [31:0] crc_q, crc_d;

  // Next CRC: preset, fold in one byte, or hold.
  always_comb begin
    crc_d = crc_q;
    if (i_init)    crc_d = CRC_INIT;
    else if (i_en) crc_d = crc32_d8(crc_q, i_data);
  end

  // CRC register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) crc_q <= CRC_INIT;
    else     crc_q <= crc_d;
  end

  assign o_crc = crc_q;
endmodule

// File: rtl/udp_pkt_rx.sv
// UDP receive parser: preamble/SFD, Ethernet II, IPv4, UDP; MAC/IP/port filter,
// cut-through payload streaming and a per-frame FCS/header verdict.
module udp_pkt_rx import eth_pkg::*; #(
  parameter logic [47:0] LOCAL_MAC   = 48'h0023543C471B,
  parameter logic [31:0] LOCAL_IP    = 32'h0A000021,
  parameter logic [15:0] LOCAL_PORT  = 16'hC350,
  parameter logic [15:0] MAX_PAYLOAD = 16'd1472
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_rx_dv,
  input  logic [7:0]  i_rxd,
  output logic [7:0]  o_data,
  output logic        o_valid,
  output logic        o_sof,
  output logic        o_eof,
  output logic [15:0] o_len,
  output logic [31:0] o_src_ip,
  output logic [15:0] o_src_port,
  output logic        o_done,
  output logic        o_good,
  output logic        o_bad,
  output logic        o_busy
);
  rx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d, cnt_inc;
  logic [7:0]  prev_q, prev_d;
  logic        mac_loc_q, mac_loc_d, mac_bc_q, mac_bc_d;
  logic        hdr_bad_q, hdr_bad_d;
  logic [15:0] csum_q, csum_d;
  logic [15:0] ip_total_q, ip_total_d;
  logic [15:0] udp_len_q, udp_len_d;
  logic [15:0] src_port_q, src_port_d;
  logic [31:0] src_ip_q, src_ip_d;

  logic [7:0]  o_data_q, o_data_d;
  logic        o_valid_q, o_valid_d, o_sof_q, o_sof_d, o_eof_q, o_eof_d;
  logic [15:0] o_len_q, o_len_d, o_src_port_q, o_src_port_d;
  logic [31:0] o_src_ip_q, o_src_ip_d;
  logic        o_done_q, o_done_d, o_good_q, o_good_d, o_bad_q, o_bad_d;
  logic        o_busy_q, o_busy_d;

  logic [15:0] word, csum_next;
  logic [16:0] csum_sum;
  logic        drop, loc_hit, bc_hit, len_bad, crc_ok, frame_ok, in_crc, in_hdr;
  logic [31:0] crc;

  // FCS covers every byte from the first destination MAC byte through the last FCS byte.
  assign in_crc = (state_q == ST_DST_MAC) || (state_q == ST_SRC_MAC) || (state_q == ST_TYPE) ||
                  (state_q == ST_IP_HDR)  || (state_q == ST_UDP_HDR) || (state_q == ST_PAYLOAD) ||
                  (state_q == ST_PAD);
  // States where losing i_rx_dv means a truncated frame.
  assign in_hdr = in_crc && (state_q != ST_PAD);

  eth_crc32_d8 u_crc (
    .clk    (clk),
    .rst    (rst),
    .i_init (!in_crc),
    .i_en   (in_crc && i_rx_dv),
    .i_data (i_rxd),
    .o_crc  (crc)
  );

  // Parser next-state, header capture and output computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    prev_d       = i_rx_dv ? i_rxd : prev_q;
    mac_loc_d    = mac_loc_q;
    mac_bc_d     = mac_bc_q;
    hdr_bad_d    = hdr_bad_q;
    csum_d       = csum_q;
    ip_total_d   = ip_total_q;
    udp_len_d    = udp_len_q;
    src_port_d   = src_port_q;
    src_ip_d     = src_ip_q;
    o_data_d     = o_data_q;
    o_valid_d    = 1'b0;
    o_sof_d      = 1'b0;
    o_eof_d      = 1'b0;
    o_len_d      = o_len_q;
    o_src_ip_d   = o_src_ip_q;
    o_src_port_d = o_src_port_q;
    o_done_d     = 1'b0;
    o_good_d     = 1'b0;
    o_bad_d      = 1'b0;
    drop         = 1'b0;

    cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    word      = {prev_q, i_rxd};
    // 1s-complement add with end-around carry; a second carry cannot occur.
    csum_sum  = {1'b0, csum_q} + {1'b0, word};
    csum_next = csum_sum[15:0] + {15'd0, csum_sum[16]};
    // MAC match is tracked byte by byte so a mismatch drops on the offending byte.
    loc_hit   = (cnt_q == 16'd0 || mac_loc_q) && (i_rxd == byte_of48(LOCAL_MAC, cnt_q[2:0]));
    bc_hit    = (cnt_q == 16'd0 || mac_bc_q) && (i_rxd == 8'hFF);
    len_bad   = (udp_len_q < 16'd8) ||
                (({1'b0, udp_len_q} + 17'd20) > {1'b0, ip_total_q}) ||
                ((udp_len_q - 16'd8) > MAX_PAYLOAD);
    crc_ok    = (bitrev32(crc) == CRC_RESIDUE);
    frame_ok  = crc_ok && (cnt_q >= 16'd4) && !hdr_bad_q;

    if (in_hdr && !i_rx_dv) begin
      state_d  = ST_VERDICT;
      o_done_d = 1'b1;
      o_bad_d  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_VERDICT: begin
          state_d = ST_IDLE;
          if (i_rx_dv) state_d = (i_rxd == PREAMBLE_BYTE) ? ST_PREAMBLE : ST_DROP;
        end
        ST_PREAMBLE: begin
          if (!i_rx_dv) state_d = ST_IDLE;
          else if (i_rxd == SFD_BYTE) begin
            state_d   = ST_DST_MAC;
            cnt_d     = 16'd0;
            hdr_bad_d = 1'b0;
          end else if (i_rxd != PREAMBLE_BYTE) state_d = ST_DROP;
        end
        ST_DST_MAC: begin
          mac_loc_d = loc_hit;
          mac_bc_d  = bc_hit;
          if (!loc_hit && !bc_hit) drop = 1'b1;
          else if (cnt_q == 16'd5) begin
            state_d = ST_SRC_MAC;
            cnt_d   = 16'd0;
          end else cnt_d = cnt_inc;
        end
        ST_SRC_MAC: begin
          if (cnt_q == 16'd5) begin
            state_d = ST_TYPE;
            cnt_d   = 16'd0;
          end else cnt_d = cnt_inc;
        end
        ST_TYPE: begin
          if (cnt_q == 16'd1) begin
            if (word != ETHERTYPE_IPV4) drop = 1'b1;
            state_d = ST_IP_HDR;
            cnt_d   = 16'd0;
            csum_d  = 16'd0;
          end else cnt_d = cnt_inc;
        end
        ST_IP_HDR: begin
          cnt_d = cnt_inc;
          if (cnt_q[0]) csum_d = csum_next;
          case (cnt_q)
            16'd0: if (i_rxd != IPV4_VER_IHL) drop = 1'b1;
            16'd3: ip_total_d = word;
            16'd6: if (i_rxd[5] || (i_rxd[4:0] != 5'd0)) drop = 1'b1;
            16'd7: if (i_rxd != 8'd0) drop = 1'b1;
            16'd9: if (i_rxd != IP_PROTO_UDP) drop = 1'b1;
            16'd12, 16'd13, 16'd14, 16'd15: src_ip_d = {src_ip_q[23:0], i_rxd};
            16'd16, 16'd17, 16'd18, 16'd19:
              if (i_rxd != byte_of32(LOCAL_IP, cnt_q[1:0])) drop = 1'b1;
            default: ;
          endcase
          if (cnt_q == 16'd19) begin
            if (csum_next != 16'hFFFF) hdr_bad_d = 1'b1;
            state_d = ST_UDP_HDR;
            cnt_d   = 16'd0;
          end
        end
        ST_UDP_HDR: begin
          cnt_d = cnt_inc;
          case (cnt_q)
            16'd1: src_port_d = word;
            16'd3: if (word != LOCAL_PORT) drop = 1'b1;
            16'd5: udp_len_d = word;
            16'd7: begin
              cnt_d     = 16'd0;
              hdr_bad_d = hdr_bad_q || len_bad;
              // A bad header still runs to PAD so the frame ends with a verdict.
              if (hdr_bad_q || len_bad) state_d = ST_PAD;
              else begin
                o_len_d      = udp_len_q - 16'd8;
                o_src_ip_d   = src_ip_q;
                o_src_port_d = src_port_q;
                state_d      = (udp_len_q == 16'd8) ? ST_PAD : ST_PAYLOAD;
              end
            end
            default: ;
          endcase
        end
        ST_PAYLOAD: begin
          o_data_d  = i_rxd;
          o_valid_d = 1'b1;
          o_sof_d   = (cnt_q == 16'd0);
          if (cnt_inc == o_len_q) begin
            o_eof_d = 1'b1;
            state_d = ST_PAD;
            cnt_d   = 16'd0;
          end else cnt_d = cnt_inc;
        end
        ST_PAD: begin
          // Fewer than 4 trailing bytes cannot hold an FCS: runt.
          if (!i_rx_dv) begin
            state_d  = ST_VERDICT;
            o_done_d = 1'b1;
            o_good_d = frame_ok;
            o_bad_d  = !frame_ok;
          end else cnt_d = cnt_inc;
        end
        ST_DROP: if (!i_rx_dv) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    if (drop) state_d = ST_DROP;

    o_busy_d = (state_d == ST_DST_MAC) || (state_d == ST_SRC_MAC) || (state_d == ST_TYPE) ||
               (state_d == ST_IP_HDR)  || (state_d == ST_UDP_HDR) || (state_d == ST_PAYLOAD) ||
               (state_d == ST_PAD)     || (state_d == ST_VERDICT);
  end

  // FSM, header capture and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      prev_q       <= '0;
      mac_loc_q    <= 1'b0;
      mac_bc_q     <= 1'b0;
      hdr_bad_q    <= 1'b0;
      csum_q       <= '0;
      ip_total_q   <= '0;
      udp_len_q    <= '0;
      src_port_q   <= '0;
      src_ip_q     <= '0;
      o_data_q     <= '0;
      o_valid_q    <= 1'b0;
      o_sof_q      <= 1'b0;
      o_eof_q      <= 1'b0;
      o_len_q      <= '0;
      o_src_ip_q   <= '0;
      o_src_port_q <= '0;
      o_done_q     <= 1'b0;
      o_good_q     <= 1'b0;
      o_bad_q      <= 1'b0;
      o_busy_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      prev_q       <= prev_d;
      mac_loc_q    <= mac_loc_d;
      mac_bc_q     <= mac_bc_d;
      hdr_bad_q    <= hdr_bad_d;
      csum_q       <= csum_d;
      ip_total_q   <= ip_total_d;
      udp_len_q    <= udp_len_d;
      src_port_q   <= src_port_d;
      src_ip_q     <= src_ip_d;
      o_data_q     <= o_data_d;
      o_valid_q    <= o_valid_d;
      o_sof_q      <= o_sof_d;
      o_eof_q      <= o_eof_d;
      o_len_q      <= o_len_d;
      o_src_ip_q   <= o_src_ip_d;
      o_src_port_q <= o_src_port_d;
      o_done_q     <= o_done_d;
      o_good_q     <= o_good_d;
      o_bad_q      <= o_bad_d;
      o_busy_q     <= o_busy_d;
    end
  end

  assign o_data     = o_data_q;
  assign o_valid    = o_valid_q;
  assign o_sof      = o_sof_q;
  assign o_eof      = o_eof_q;
  assign o_len      = o_len_q;
  assign o_src_ip   = o_src_ip_q;
  assign o_src_port = o_src_port_q;
  assign o_done     = o_done_q;
  assign o_good     = o_good_q;
  assign o_bad      = o_bad_q;
  assign o_busy     = o_busy_q;
endmodule
